// File: rtl/poly_encode12.sv
// Reduces 12-bit coefficients mod Q and packs each pair into 3 bytes. A pair costs 5 cycles when both streams run freely.
// Backpressure: byte_ready low holds byte_data/byte_last stable, and coef_ready drops while bytes drain.
module poly_encode12 #(
  parameter int Q = 3329,
  parameter int N = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  input  logic [11:0] coef_data,
  input  logic        coef_valid,
  output logic        coef_ready,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last
);

  localparam int PW = (N > 2) ? $clog2(N / 2) : 1;
  localparam logic [PW-1:0] PLAST = PW'(N / 2 - 1);
  localparam logic [11:0] QV = 12'(Q);

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, EMIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [11:0]   r0, r1;
  logic [1:0]    bcnt;
  logic [PW-1:0] pcnt;
  logic          coef_xfer, byte_xfer;

  function automatic logic [11:0] reduce(input logic [11:0] c);
    reduce = (c >= QV) ? (c - QV) : c;
  endfunction

  assign coef_xfer = coef_valid && coef_ready;
  assign byte_xfer = byte_valid && byte_ready;

  always_comb begin
    state_nxt  = state;
    coef_ready = 1'b0;
    byte_valid = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD0;
      LOAD0: begin
        coef_ready = 1'b1;
        if (coef_valid) state_nxt = LOAD1;
      end
      LOAD1: begin
        coef_ready = 1'b1;
        if (coef_valid) state_nxt = EMIT;
      end
      EMIT: begin
        byte_valid = 1'b1;
        if (byte_ready && bcnt == 2'd2) state_nxt = (pcnt == PLAST) ? DONE : LOAD0;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r0    <= '0;
      r1    <= '0;
      bcnt  <= '0;
      pcnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          bcnt <= '0;
          pcnt <= '0;
        end
        LOAD0: if (coef_xfer) r0 <= reduce(coef_data);
        LOAD1: if (coef_xfer) begin
          r1   <= reduce(coef_data);
          bcnt <= '0;
        end
        EMIT: if (byte_xfer) begin
          if (bcnt == 2'd2) begin
            bcnt <= '0;
            // Saturates at the last pair so the counter never wraps inside a frame.
            if (pcnt != PLAST) pcnt <= pcnt + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_data = 8'h00;
    if (state == EMIT) begin
      case (bcnt)
        2'd0:    byte_data = r0[7:0];
        2'd1:    byte_data = {r1[3:0], r0[11:8]};
        default: byte_data = r1[11:4];
      endcase
    end
  end

  assign byte_last = (state == EMIT) && (bcnt == 2'd2) && (pcnt == PLAST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: doc/poly_encode12.md
POLY_ENCODE12 -- requirements
Module: poly_encode12

Interface
REQ-001 Parameter Q, default 3329: modulus for the final conditional reduction.
REQ-002 Parameter N, default 256: coefficients per polynomial; N SHALL be even.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin encoding one polynomial.
REQ-006 busy  output  1  high from the cycle after an accepted start until done.
REQ-007 done  output  1  one-cycle pulse after the last byte is accepted.
REQ-008 coef_data  input  12  coefficient, range 0..4095, index order 0..N-1.
REQ-009 coef_valid  input  1  coef_data is valid.
REQ-010 coef_ready  output  1  block accepts coef_data this cycle.
REQ-011 byte_data  output  8  encoded byte.
REQ-012 byte_valid  output  1  byte_data is valid.
REQ-013 byte_ready  input  1  downstream accepts byte_data this cycle.
REQ-014 byte_last  output  1  high with byte_valid on byte index 3N/2-1 only.

Function
REQ-015 Transfer on either stream SHALL occur only in a cycle where valid and ready are both high.
REQ-016 Each coefficient c SHALL be reduced on acceptance: r = c-Q if c>=Q, else r = c; r SHALL be stored as 12 bits.
REQ-017 Pair (r0,r1) at indices 2k, 2k+1 SHALL produce bytes 3k..3k+2: r0[7:0]; {r1[3:0], r0[11:8]}; r1[11:4].
REQ-018 FSM states: IDLE, LOAD0, LOAD1, EMIT, DONE.
REQ-019 IDLE: start=1 -> LOAD0, pair counter 0, byte index 0; otherwise stay.
REQ-020 LOAD0: coef_ready=1; on transfer store r0 -> LOAD1.
REQ-021 LOAD1: coef_ready=1; on transfer store r1 -> EMIT, byte counter 0.
REQ-022 EMIT: byte_valid=1, byte_data selected by byte counter; on transfer counter increments; on transfer at counter 2: pair counter = N/2-1 -> DONE, else pair counter +1 -> LOAD0.
REQ-023 DONE: done=1 for exactly one cycle -> IDLE.
REQ-024 coef_ready SHALL be 0 outside LOAD0/LOAD1; byte_valid SHALL be 0 outside EMIT.
REQ-025 While byte_valid=1 and byte_ready=0, byte_data and byte_last SHALL hold stable.
REQ-026 busy SHALL be 1 in LOAD0, LOAD1, EMIT, DONE; 0 in IDLE.
REQ-027 start outside IDLE SHALL be ignored and SHALL NOT disturb the current frame.
REQ-028 coef_valid in IDLE/EMIT/DONE SHALL be ignored; no coefficient is consumed.
REQ-029 Latency: first byte_valid one cycle after the second coefficient transfer; with byte_ready tied high a pair takes 5 cycles, a frame 5N/2 + 2 cycles from start to done.
REQ-030 Pair counter width SHALL be ceil(log2(N/2)) bits and SHALL NOT wrap within a frame.

Reset
REQ-031 rst=1 SHALL force IDLE, clear all counters and holding registers, and drive busy, done, coef_ready, byte_valid, byte_last to 0 and byte_data to 0x00 at the next edge.
REQ-032 rst asserted mid-frame SHALL abandon the frame without a done pulse; the next start SHALL begin at coefficient 0.
REQ-033 rst SHALL take priority over start and all handshakes in the same cycle.

Verification
REQ-034 Start, coefficients 0x123, 0x456, byte_ready=1 -> bytes 0x23, 0x61, 0x45 in consecutive cycles.
REQ-035 Reduction: pair (4095, 3329) -> r=(766, 0) -> bytes 0xFE, 0x02, 0x00; pair (3328, 0) -> 0x00, 0x0D, 0x00.
REQ-036 Full frame, coef i = i mod 3329, byte_ready=1 -> 384 bytes matching the reference packing, byte_last only on byte 383, done one cycle after it, total 642 cycles start-to-done.
REQ-037 Random byte_ready and coef_valid gaps -> identical byte sequence to REQ-036; byte_data stable during every stall.
REQ-038 rst asserted at byte 100 of a frame, then new start -> no done pulse for the aborted frame; new frame output matches REQ-036 from byte 0.
REQ-039 start pulsed while in EMIT -> ignored; frame completes with exactly 384 bytes and one done pulse.
